// File: rtl/ara_w_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : ara_w_trace_unit
// Purpose  : Snoops NrPorts AXI W channels and records strobe-qualified,
//            handshaked beats into a timestamped trace FIFO drained by valid/ready.
// Revision : 1.0
// ============================================================================
module ara_w_trace_unit #(
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned DataWidth = 256,
    parameter int unsigned Depth     = 16,
    parameter int unsigned CntWidth  = 32,
    localparam int unsigned StrbW    = DataWidth / 8,
    localparam int unsigned PortW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrPorts*DataWidth-1:0]   w_data_i,
    input  logic [NrPorts*StrbW-1:0]       w_strb_i,
    input  logic [NrPorts-1:0]             w_valid_i,
    input  logic [NrPorts-1:0]             w_ready_i,
    input  logic                           dump_en_i,
    input  logic [63:0]                    trigger_i,
    input  logic                           clear_i,
    output logic                           trace_valid_o,
    input  logic                           trace_ready_i,
    output logic [PortW-1:0]               trace_port_o,
    output logic [DataWidth-1:0]           trace_data_o,
    output logic [StrbW-1:0]               trace_strb_o,
    output logic [CntWidth-1:0]            trace_time_o,
    output logic [1:0]                     state_o,
    output logic [CntWidth-1:0]            beat_cnt_o,
    output logic [CntWidth-1:0]            drop_cnt_o
);

    localparam int unsigned ADDR_W  = $clog2(Depth);
    localparam int unsigned ENTRY_W = PortW + DataWidth + StrbW + CntWidth;
    localparam logic [63:0] TRIG_ON  = 64'h1;
    localparam logic [63:0] TRIG_OFF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(Depth);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STOPPED = 2'd2
    } state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   ts_q;
    logic [CntWidth-1:0]   beat_cnt_q;
    logic [CntWidth-1:0]   drop_cnt_q;
    logic [ADDR_W-1:0]     wr_ptr_q;
    logic [ADDR_W-1:0]     rd_ptr_q;
    logic [ADDR_W:0]       count_q;
    logic [ENTRY_W-1:0]    mem_q [Depth];

    logic [NrPorts-1:0]    qual;
    logic                  win_found;
    logic [PortW-1:0]      win_idx;
    logic [DataWidth-1:0]  win_data;
    logic [StrbW-1:0]      win_strb;
    logic [CntWidth-1:0]   n_losers;
    logic [CntWidth-1:0]   drop_inc;
    logic                  pop;
    logic                  full;
    logic                  push;
    logic [ENTRY_W-1:0]    head;

    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                    input logic [CntWidth-1:0] b);
        logic [CntWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CntWidth] ? {CntWidth{1'b1}} : s[CntWidth-1:0];
    endfunction

    // Arbitration: scanning downward leaves the lowest-index qualified port as winner.
    always_comb begin
        qual      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        win_strb  = '0;
        n_losers  = '0;
        for (int p = 0; p < NrPorts; p++) begin
            qual[p] = (state_q == ST_CAPTURE) && dump_en_i && w_valid_i[p] && w_ready_i[p]
                      && (|w_strb_i[p*StrbW +: StrbW]);
        end
        for (int p = NrPorts - 1; p >= 0; p--) begin
            if (qual[p]) begin
                win_found = 1'b1;
                win_idx   = PortW'(p);
                win_data  = w_data_i[p*DataWidth +: DataWidth];
                win_strb  = w_strb_i[p*StrbW +: StrbW];
            end
        end
        for (int p = 0; p < NrPorts; p++) begin
            n_losers = n_losers + CntWidth'(qual[p]);
        end
        if (win_found) begin
            n_losers = n_losers - CntWidth'(1);
        end
    end

    assign full     = (count_q == FULL_CNT);
    assign pop      = trace_valid_o && trace_ready_i;
    assign push     = win_found && (!full || pop);
    assign drop_inc = n_losers + CntWidth'(win_found && !push);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            beat_cnt_q <= '0;
            drop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger_i == TRIG_ON) begin
                        state_q <= ST_CAPTURE;
                        ts_q    <= '0;
                    end
                end
                ST_CAPTURE: begin
                    ts_q <= ts_q + CntWidth'(1);
                    if (trigger_i == TRIG_OFF) begin
                        state_q <= ST_STOPPED;
                    end
                end
                ST_STOPPED: begin
                    if (trigger_i == TRIG_ON) begin
                        state_q <= ST_CAPTURE;
                        ts_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            beat_cnt_q <= sat_add(beat_cnt_q, CntWidth'(push));
            drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);

            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            count_q <= count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
        end
    end

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !clear_i) begin
            mem_q[wr_ptr_q] <= {win_idx, win_data, win_strb, ts_q};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign trace_valid_o = (count_q != '0);
    assign trace_port_o  = trace_valid_o ? head[ENTRY_W-1 -: PortW] : '0;
    assign trace_data_o  = trace_valid_o ? head[StrbW+CntWidth +: DataWidth] : '0;
    assign trace_strb_o  = trace_valid_o ? head[CntWidth +: StrbW] : '0;
    assign trace_time_o  = trace_valid_o ? head[CntWidth-1:0] : '0;
    assign state_o       = state_q;
    assign beat_cnt_o    = beat_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ara_w_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ara_w_trace_unit
// Purpose  : Directed and random stimulus for ara_w_trace_unit against a
//            queue-based reference model of the trace capture behaviour.
// Revision : 1.0
// ============================================================================
module tb_ara_w_trace_unit;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int DEPTH = 16;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  w_data;
    logic [NP*SW-1:0]  w_strb;
    logic [NP-1:0]     w_valid;
    logic [NP-1:0]     w_ready;
    logic              dump_en;
    logic [63:0]       trigger;
    logic              clear;
    logic              trace_valid;
    logic              trace_ready;
    logic [1:0]        trace_port;
    logic [DW-1:0]     trace_data;
    logic [SW-1:0]     trace_strb;
    logic [CW-1:0]     trace_time;
    logic [1:0]        state;
    logic [CW-1:0]     beat_cnt;
    logic [CW-1:0]     drop_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [31:0] t;
    } ent_t;

    ent_t        m_q[$];
    int          m_state = 0;
    logic [31:0] m_ts = 0;
    longint      m_beat = 0;
    longint      m_drop = 0;

    ara_w_trace_unit #(
        .NrPorts(NP), .DataWidth(DW), .Depth(DEPTH), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_i(w_ready),
        .dump_en_i(dump_en), .trigger_i(trigger), .clear_i(clear),
        .trace_valid_o(trace_valid), .trace_ready_i(trace_ready),
        .trace_port_o(trace_port), .trace_data_o(trace_data), .trace_strb_o(trace_strb),
        .trace_time_o(trace_time), .state_o(state),
        .beat_cnt_o(beat_cnt), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic longint sat(longint a, longint b);
        longint s = a + b;
        return (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int   nq;
        int   winner;
        bit   pop;
        bit   acc;
        ent_t e;
        if (rst || clear) begin
            m_state = 0; m_ts = 0; m_beat = 0; m_drop = 0;
            m_q.delete();
            return;
        end
        pop = (m_q.size() != 0) && trace_ready;
        nq = 0; winner = -1; acc = 0;
        for (int p = 0; p < NP; p++) begin
            if (m_state == 1 && dump_en && w_valid[p] && w_ready[p] && w_strb[p*SW +: SW] != 0) begin
                nq++;
                if (winner < 0) winner = p;
            end
        end
        if (nq > 0) acc = (m_q.size() < DEPTH) || pop;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            e.port = winner;
            e.data = w_data[winner*DW +: DW];
            e.strb = w_strb[winner*SW +: SW];
            e.t    = m_ts;
            m_q.push_back(e);
        end
        m_beat = sat(m_beat, acc ? 1 : 0);
        if (nq > 0) m_drop = sat(m_drop, nq - (acc ? 1 : 0));
        if (m_state == 1) begin
            m_ts = m_ts + 1;
            if (trigger == 64'hFFFF_FFFF_FFFF_FFFF) m_state = 2;
        end else if (trigger == 64'h1) begin
            m_state = 1;
            m_ts = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("state", 64'(state), 64'(m_state));
        chk("beat_cnt", 64'(beat_cnt), 64'(m_beat));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("valid", 64'(trace_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("port", 64'(trace_port), 64'(m_q[0].port));
            chk("data", trace_data, m_q[0].data);
            chk("strb", 64'(trace_strb), 64'(m_q[0].strb));
            chk("time", 64'(trace_time), 64'(m_q[0].t));
        end else begin
            chk("empty_data", {trace_data ^ 64'(trace_time)}, 64'(trace_port) | 64'(trace_strb));
            chk("empty_zero", trace_data | 64'(trace_time) | 64'(trace_strb) | 64'(trace_port), 64'h0);
        end
    endtask

    task automatic idle_in();
        w_valid = '0; w_ready = '0; w_strb = '0; w_data = '0;
    endtask

    task automatic beat(int p, logic [63:0] d, logic [7:0] s);
        w_valid[p] = 1'b1; w_ready[p] = 1'b1;
        w_data[p*DW +: DW] = d; w_strb[p*SW +: SW] = s;
    endtask

    initial begin
        rst = 1; clear = 0; dump_en = 1; trigger = '0; trace_ready = 0;
        idle_in();
        cycle(); cycle();
        rst = 0;
        cycle();

        // First capture: trigger one cycle, beat three cycles later carries time 2
        trigger = 64'h1; cycle();
        trigger = '0; cycle(); cycle();
        beat(0, 64'hA5A5_A5A5_A5A5_A5A5, 8'h0F); cycle();
        idle_in();
        chk("t1_time", 64'(trace_time), 64'd2);
        chk("t1_port", 64'(trace_port), 64'd0);
        chk("t1_beat", 64'(beat_cnt), 64'd1);
        trace_ready = 1; cycle(); trace_ready = 0;

        // Simultaneous beats: two ports, then all four
        beat(0, 64'h11, 8'h01); beat(1, 64'h22, 8'h02); cycle();
        idle_in();
        for (int p = 0; p < NP; p++) beat(p, 64'(p + 100), 8'hF0);
        cycle();
        idle_in();
        chk("multi_drop", 64'(drop_cnt), 64'd4);
        trace_ready = 1; cycle(); cycle(); cycle(); trace_ready = 0;

        // Overfill with the consumer stalled, then hold
        for (int i = 0; i < 20; i++) begin
            idle_in(); beat(1, 64'(i) | 64'hBEEF_0000_0000_0000, 8'hFF); cycle();
        end
        idle_in();
        chk("fill_drop", 64'(drop_cnt), 64'd8);
        for (int i = 0; i < 5; i++) cycle();

        // Full FIFO, simultaneous push and pop
        beat(2, 64'hC0FFEE, 8'h80); trace_ready = 1; cycle();
        idle_in();
        chk("fullpp_drop", 64'(drop_cnt), 64'd8);
        for (int i = 0; i < 18; i++) cycle();
        trace_ready = 0;

        // Non-qualifying beats
        dump_en = 0; beat(0, 64'h1, 8'h1); cycle();
        dump_en = 1; idle_in(); beat(1, 64'h2, 8'h0); cycle();
        idle_in(); w_valid[2] = 1; w_strb[2*SW +: SW] = 8'hFF; cycle();
        idle_in();

        // Stop, beats ignored, queued entries still drain
        beat(3, 64'h33, 8'h3); trigger = 64'hFFFF_FFFF_FFFF_FFFF; cycle();
        trigger = '0;
        for (int i = 0; i < 3; i++) begin idle_in(); beat(0, 64'h44, 8'h4); cycle(); end
        idle_in(); trace_ready = 1; cycle(); cycle(); trace_ready = 0;
        trigger = 64'h1; cycle(); trigger = '0;
        beat(1, 64'h55, 8'h5); cycle(); idle_in();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NP; p++) begin
                w_valid[p] = 1'($urandom_range(0, 1));
                w_ready[p] = 1'($urandom_range(0, 2) != 0);
                w_strb[p*SW +: SW] = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom);
                w_data[p*DW +: DW] = {$urandom, $urandom};
            end
            dump_en = ($urandom_range(0, 9) != 0);
            trace_ready = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 99))
                0, 1, 2, 3, 4: trigger = 64'h1;
                5, 6:          trigger = 64'hFFFF_FFFF_FFFF_FFFF;
                7:             trigger = {$urandom, $urandom};
                default:       trigger = '0;
            endcase
            clear = ($urandom_range(0, 199) == 0);
            cycle();
        end
        clear = 0; trigger = '0; dump_en = 1; trace_ready = 0; idle_in();

        // Clear together with trigger ON, mid-capture
        rst = 1; cycle(); rst = 0;
        trigger = 64'h1; cycle(); trigger = '0;
        beat(0, 64'h66, 8'h6); cycle(); beat(1, 64'h77, 8'h7); cycle(); idle_in();
        clear = 1; trigger = 64'h1; cycle(); clear = 0; trigger = '0;
        chk("clr_state", 64'(state), 64'd0);
        chk("clr_valid", 64'(trace_valid), 64'd0);
        chk("clr_beat", 64'(beat_cnt), 64'd0);

        trigger = 64'h1; cycle(); trigger = '0;
        beat(0, 64'h88, 8'h8); cycle(); idle_in();
        rst = 1; trigger = 64'h1; cycle(); rst = 0; trigger = '0;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_beat", 64'(beat_cnt), 64'd0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
